// File: rtl/huffman_code_gen.sv
// huffman_code_gen: latches a 19-node Huffman tree, walks every leaf up to the root and
// builds the 10-entry {len[3:0], code[8:0]} table. Define GENCODE_SWAP_EN for left=1 / right=0.
module huffman_code_gen (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [19:1][27:0] node_i,
  input  logic              tree_over_i,
  output logic [129:0]      code_table_o,
  output logic              over_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_INIT  = 3'd2,
    ST_CLIMB = 3'd3,
    ST_STORE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  sym_q, sym_d;
  logic [4:0]  cur_q, cur_d;
  logic [3:0]  len_q, len_d;
  logic [8:0]  code_q, code_d;
  logic        over_q;
  logic [4:0]  par_q   [32];
  logic [4:0]  left_q  [32];
  logic [4:0]  right_q [32];
  logic [12:0] entry_q [10];

  logic        latch_en_s;
  logic        store_en_s;
  logic [4:0]  p_s;
  logic [4:0]  p_par_s;
  logic [4:0]  p_left_s;
  logic [4:0]  p_right_s;
  logic        bit_s;
  logic        stop_s;
  logic        unused_node_s;

  // Node lookups; ids 0 and 20..31 hit reset-only slots (parent 0, children 31).
  assign p_s       = par_q[cur_q];
  assign p_par_s   = par_q[p_s];
  assign p_left_s  = left_q[p_s];
  assign p_right_s = right_q[p_s];

  // A parent that claims neither child as cur still yields bit 1 in both polarities.
`ifdef GENCODE_SWAP_EN
  assign bit_s = (p_right_s != cur_q);
`else
  assign bit_s = (p_left_s != cur_q);
`endif

  assign stop_s = (p_s == 5'd0) || (p_s > 5'd19) || (len_q >= 4'd9);

  // Frequency and own-id fields are not needed to build codes.
  always_comb begin
    unused_node_s = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      unused_node_s = unused_node_s ^ (^node_i[k][12:0]);
    end
  end

  // Next-state and walk datapath.
  always_comb begin
    state_d    = state_q;
    sym_d      = sym_q;
    cur_d      = cur_q;
    len_d      = len_q;
    code_d     = code_q;
    latch_en_s = 1'b0;
    store_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tree_over_i) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        latch_en_s = 1'b1;
        sym_d      = 4'd1;
        state_d    = ST_INIT;
      end
      ST_INIT: begin
        cur_d   = {1'b0, sym_q};
        len_d   = 4'd0;
        code_d  = 9'd0;
        state_d = ST_CLIMB;
      end
      ST_CLIMB: begin
        if (stop_s) begin
          state_d = ST_STORE;
        end else begin
          code_d = code_q | (9'(bit_s) << len_q);
          len_d  = len_q + 4'd1;
          cur_d  = p_s;
          // Finish in the same cycle the root is reached so each level costs one cycle.
          if ((p_par_s == 5'd0) || (len_q == 4'd8)) begin
            state_d = ST_STORE;
          end else begin
            state_d = ST_CLIMB;
          end
        end
      end
      ST_STORE: begin
        store_en_s = 1'b1;
        if (sym_q == 4'd10) begin
          state_d = ST_DONE;
        end else begin
          sym_d   = sym_q + 4'd1;
          state_d = ST_INIT;
        end
      end
      ST_DONE: begin
        if (!tree_over_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, walk registers and the registered completion flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sym_q   <= 4'd0;
      cur_q   <= 5'd0;
      len_q   <= 4'd0;
      code_q  <= 9'd0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      cur_q   <= cur_d;
      len_q   <= len_d;
      code_q  <= code_d;
      over_q  <= (state_d == ST_DONE);
    end
  end

  // Tree snapshot taken in LATCH; later input changes are ignored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 32; k++) begin
        par_q[k]   <= 5'd0;
        left_q[k]  <= 5'd31;
        right_q[k] <= 5'd31;
      end
    end else if (latch_en_s) begin
      for (int k = 1; k <= 19; k++) begin
        par_q[k]   <= node_i[k][27:23];
        left_q[k]  <= node_i[k][22:18];
        right_q[k] <= node_i[k][17:13];
      end
    end
  end

  // Code table entries change only in STORE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < 10; e++) begin
        entry_q[e] <= 13'd0;
      end
    end else if (store_en_s) begin
      entry_q[sym_q - 4'd1] <= {len_q, code_q};
    end
  end

  // Flatten entries onto the output bus.
  always_comb begin
    code_table_o = 130'd0;
    for (int e = 0; e < 10; e++) begin
      code_table_o[13*e +: 13] = entry_q[e];
    end
  end

  assign over_o = over_q;

endmodule

// File: tb/tb_huffman_code_gen.sv
// Self-checking bench for huffman_code_gen: table of tree runs plus handshake and reset sequences.
module tb_huffman_code_gen;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tree_over;
  logic              over;
  logic [19:1][27:0] node;
  logic [129:0]      table_s;

  huffman_code_gen dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .node_i       (node),
    .tree_over_i  (tree_over),
    .code_table_o (table_s),
    .over_o       (over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               tree_sel;   // 0 standard, 1 chain, 2 chain with node 18 parent = 25
    int               exp_cycles; // exact latency, or -1 for bound-only
    int               max_cycles;
    bit               scramble;   // trash inputs after LATCH
    logic [9:0][12:0] exp_entry;
  } vec_t;

  vec_t        vecs[4];
  logic [12:0] sb_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] mk(input int len, input int code);
    logic [12:0] e;
    e = {4'(len), 9'(code)};
`ifdef GENCODE_SWAP_EN
    e[8:0] = e[8:0] ^ ((9'd1 << e[12:9]) - 9'd1);
`endif
    return e;
  endfunction

  task automatic load_tree(input int sel);
    int par[20];
    int lc[20];
    int rc[20];
    int std_par[19] = '{18,18,17,16,15,12,12,13,11,11,13,14,14,15,16,17,19,19,0};
    for (int k = 0; k < 20; k++) begin
      par[k] = 0;
      lc[k]  = 31;
      rc[k]  = 31;
    end
    if (sel == 0) begin
      for (int k = 1; k <= 19; k++) par[k] = std_par[k-1];
      lc[11] = 9;  rc[11] = 10; lc[12] = 7;  rc[12] = 6;  lc[13] = 8;  rc[13] = 11;
      lc[14] = 13; rc[14] = 12; lc[15] = 5;  rc[15] = 14; lc[16] = 4;  rc[16] = 15;
      lc[17] = 16; rc[17] = 3;  lc[18] = 1;  rc[18] = 2;  lc[19] = 18; rc[19] = 17;
    end else begin
      for (int k = 1; k <= 8; k++) par[k] = 20 - k;
      par[9]  = 11;
      par[10] = 11;
      for (int n = 11; n <= 18; n++) par[n] = n + 1;
      par[19] = 0;
      lc[11] = 9;
      rc[11] = 10;
      for (int n = 12; n <= 19; n++) begin
        lc[n] = n - 1;
        rc[n] = 20 - n;
      end
      if (sel == 2) par[18] = 25;
    end
    for (int k = 1; k <= 19; k++) begin
      node[k] = {5'(par[k]), 5'(lc[k]), 5'(rc[k]), 8'(k * 7), 5'(k)};
    end
  endtask

  initial begin
    int            n;
    logic [129:0]  prev;
    logic [12:0]   exp_e;

    vecs[0].tree_sel   = 0;
    vecs[0].exp_cycles = 66;
    vecs[0].max_cycles = 200;
    vecs[0].scramble   = 1'b0;
    vecs[0].exp_entry[0] = mk(2, 0);
    vecs[0].exp_entry[1] = mk(2, 1);
    vecs[0].exp_entry[2] = mk(2, 3);
    vecs[0].exp_entry[3] = mk(3, 4);
    vecs[0].exp_entry[4] = mk(4, 10);
    vecs[0].exp_entry[5] = mk(6, 47);
    vecs[0].exp_entry[6] = mk(6, 46);
    vecs[0].exp_entry[7] = mk(6, 44);
    vecs[0].exp_entry[8] = mk(7, 90);
    vecs[0].exp_entry[9] = mk(7, 91);
    vecs[1]          = vecs[0];
    vecs[1].scramble = 1'b1;
    vecs[2].tree_sel   = 1;
    vecs[2].exp_cycles = 75;
    vecs[2].max_cycles = 200;
    vecs[2].scramble   = 1'b0;
    for (int k = 1; k <= 8; k++) vecs[2].exp_entry[k-1] = mk(k, 1);
    vecs[2].exp_entry[8] = mk(9, 0);
    vecs[2].exp_entry[9] = mk(9, 1);
    vecs[3].tree_sel   = 2;
    vecs[3].exp_cycles = -1;
    vecs[3].max_cycles = 111;
    vecs[3].scramble   = 1'b0;
    vecs[3].exp_entry[0] = mk(1, 1);
    vecs[3].exp_entry[1] = mk(1, 1);
    for (int k = 3; k <= 8; k++) vecs[3].exp_entry[k-1] = mk(k - 1, 1);
    vecs[3].exp_entry[8] = mk(8, 0);
    vecs[3].exp_entry[9] = mk(8, 1);

    // Reset held with a start request pending.
    tree_over = 1'b1;
    rst_n     = 1'b0;
    load_tree(vecs[0].tree_sel);
    repeat (3) @(posedge clk);
    #1;
    check("reset_table", table_s, 130'd0);
    check("reset_over", {129'd0, over}, 130'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        prev = table_s;
        @(negedge clk) tree_over = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("hs%0d_over_drop", i), {129'd0, over}, 130'd0);
        check($sformatf("hs%0d_table_hold", i), table_s, prev);
        @(negedge clk);
        load_tree(vecs[i].tree_sel);
        tree_over = 1'b1;
      end
      for (int e = 0; e < 10; e++) sb_q.push_back(vecs[i].exp_entry[e]);
      @(posedge clk);
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
        if (vecs[i].scramble && n == 3) begin
          for (int k = 1; k <= 19; k++) node[k] = 28'($urandom);
        end
      end while (!over && n < vecs[i].max_cycles);
      if (vecs[i].exp_cycles > 0) begin
        check($sformatf("vec%0d_latency", i), 130'(n), 130'(vecs[i].exp_cycles));
      end else begin
        check($sformatf("vec%0d_over_in_bound", i), {129'd0, over}, 130'd1);
      end
      for (int e = 0; e < 10; e++) begin
        exp_e = sb_q.pop_front();
        check($sformatf("vec%0d_entry%0d", i, e + 1), {117'd0, table_s[13*e +: 13]}, {117'd0, exp_e});
      end
    end

    // Reset in the middle of the first CLIMB.
    @(negedge clk) tree_over = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load_tree(0);
    tree_over = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midclimb_reset_table", table_s, 130'd0);
    check("midclimb_reset_over", {129'd0, over}, 130'd0);
    @(negedge clk) tree_over = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_idle_over", {129'd0, over}, 130'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
